keypad_matrix_responder: RTL and testbench

- Synthesizable keypad emulator that forms the far end of the keypad scan interface. It watches the scanner's scan strobes and drives the 3-bit sense lines as if a 4x3 matrix keypad were pressed.
- Key presses come from a scripted command queue (valid/ready) or from a static force map.
- Used for on-board loopback self-test of the keypad scanner and the downstream OX-detection path, with no physical keypad attached.

---
 rtl/keypad_pkg.sv | 51 +++++
 rtl/keypad_matrix_responder_tick.sv | 31 +++
 rtl/keypad_matrix_responder.sv | 154 +++++++++++++++
 tb/tb_keypad_matrix_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key table for the keypad matrix responder.
// Keys are numbered row-major over a 4x3 matrix: 1 2 3 / 4 5 6 / 7 8 9 / * 0 #.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP
  } state_t;

  localparam int NUM_KEYS = 12;
  localparam int KEY_COLS = 3;

  localparam logic [3:0] KEY_1    = 4'd0;
  localparam logic [3:0] KEY_2    = 4'd1;
  localparam logic [3:0] KEY_3    = 4'd2;
  localparam logic [3:0] KEY_4    = 4'd3;
  localparam logic [3:0] KEY_5    = 4'd4;
  localparam logic [3:0] KEY_6    = 4'd5;
  localparam logic [3:0] KEY_7    = 4'd6;
  localparam logic [3:0] KEY_8    = 4'd7;
  localparam logic [3:0] KEY_9    = 4'd8;
  localparam logic [3:0] KEY_STAR = 4'd9;
  localparam logic [3:0] KEY_0    = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef struct packed {
    logic [1:0] scan;
    logic [1:0] sense;
  } key_pos_t;

  function automatic key_pos_t key_pos(
    input logic [3:0] k
  );
    key_pos_t p;
    p.scan  = 2'(k / 4'd3);
    p.sense = 2'(k % 4'd3);
    return p;
  endfunction

  function automatic logic [NUM_KEYS-1:0] key_onehot(
    input logic [3:0] k
  );
    key_pos_t p;
    int       idx;
    p   = key_pos(k);
    idx = int'(p.scan) * KEY_COLS + int'(p.sense);
    return {{(NUM_KEYS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/keypad_matrix_responder_tick.sv
// Hold-tick prescaler: one-clock tick every TICK_DIV clocks,
// restartable with a synchronous clear.
module keypad_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST =
    W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_matrix_responder.sv
// Keypad emulator: answers scan strobes with sense lines for the
// scripted key (command queue) ORed with a static force map.
module keypad_matrix_responder
  import keypad_pkg::*;
#(
  parameter int NUM_SCAN  = 4,
  parameter int NUM_SENSE = 3,
  parameter int TICK_DIV  = 50000,
  parameter int GAP_TICKS = 20,
  parameter int SENSE_DLY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SCAN-1:0]  scan_in,
  output logic [NUM_SENSE-1:0] sense_out,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_key,
  input  logic [15:0]          cmd_hold,
  input  logic [NUM_KEYS-1:0]  force_map,
  output logic [NUM_KEYS-1:0]  pressed_map,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [15:0] GAP_LOAD =
    16'(GAP_TICKS);

  state_t                state, state_n;
  logic [15:0]           hold_cnt, hold_n;
  logic [3:0]            cur_key, key_n;
  logic                  err_n;
  logic                  accept;
  logic                  tick;
  logic [NUM_KEYS-1:0]   map_n;
  logic [NUM_SENSE-1:0]  raw;
  logic [NUM_SENSE-1:0]  pipe [SENSE_DLY];

  keypad_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    hold_n    = hold_cnt;
    key_n     = cur_key;
    accept    = 1'b0;
    err_n     = 1'b0;
    done      = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          if (cmd_key > KEY_HASH) begin
            err_n = 1'b1;
          end else begin
            accept  = 1'b1;
            key_n   = cmd_key;
            hold_n  = (cmd_hold == 16'd0) ?
                      16'd1 : cmd_hold;
            state_n = PRESS;
          end
        end
      end
      PRESS: begin
        if (tick) begin
          if (hold_cnt == 16'd1) begin
            hold_n  = GAP_LOAD;
            state_n = GAP;
          end else begin
            hold_n = hold_cnt - 16'd1;
          end
        end
      end
      GAP: begin
        // a zero-length gap still spends one clock here
        if (hold_cnt == 16'd0 ||
            (tick && hold_cnt == 16'd1)) begin
          done    = 1'b1;
          state_n = IDLE;
        end else if (tick) begin
          hold_n = hold_cnt - 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    map_n = force_map;
    if (state == PRESS) begin
      map_n = map_n | key_onehot(cur_key);
    end
  end

  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_SCAN; i++) begin
      for (int j = 0; j < NUM_SENSE; j++) begin
        raw[j] = raw[j] |
          (scan_in[i] & pressed_map[i*NUM_SENSE+j]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt    <= '0;
      cur_key     <= '0;
      err         <= 1'b0;
      pressed_map <= '0;
    end else begin
      hold_cnt    <= hold_n;
      cur_key     <= key_n;
      err         <= err_n;
      pressed_map <= map_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SENSE_DLY; k++) begin
        pipe[k] <= '0;
      end
    end else begin
      pipe[0] <= raw;
      for (int k = 1; k < SENSE_DLY; k++) begin
        pipe[k] <= pipe[k-1];
      end
    end
  end

  assign sense_out = pipe[SENSE_DLY-1];

endmodule

// File: tb/tb_keypad_matrix_responder.sv
// Bench for keypad_matrix_responder: directed scenarios plus random
// traffic, checked against a time-window model of press/gap/done.
module tb_keypad_matrix_responder;

  localparam int TD = 4;
  localparam int G  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  scan_in = '0;
  logic [2:0]  sense_out;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_key = '0;
  logic [15:0] cmd_hold = '0;
  logic [11:0] force_map = '0;
  logic [11:0] pressed_map;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  keypad_matrix_responder #(
    .NUM_SCAN  (4),
    .NUM_SENSE (3),
    .TICK_DIV  (TD),
    .GAP_TICKS (G),
    .SENSE_DLY (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scan_in     (scan_in),
    .sense_out   (sense_out),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_key     (cmd_key),
    .cmd_hold    (cmd_hold),
    .force_map   (force_map),
    .pressed_map (pressed_map),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;
  int plen = 0;

  bit          m_act = 1'b0;
  int          m_a, m_pend, m_aend;
  logic [3:0]  m_key = '0;
  bit          p_press = 1'b0;
  bit          p_err = 1'b0;
  logic [3:0]  p_key = '0;
  logic [3:0]  p_scan = '0;
  logic [11:0] p_force = '0;
  logic [11:0] p_pm = '0;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  tag, got, exp, cyc);
  endtask

  function automatic logic [11:0] key_bit(input logic [3:0] k);
    int row, col;
    row = int'(k) / 3;
    col = int'(k) % 3;
    return 12'(1) << (row * 3 + col);
  endfunction

  function automatic logic [2:0] sense_of(
    input logic [3:0] s, input logic [11:0] pm);
    logic [2:0] r;
    r = 3'b0;
    for (int row = 0; row < 4; row++)
      if (s[row]) r = r | pm[row*3 +: 3];
    return r;
  endfunction

  task automatic model_clear();
    m_act = 1'b0; p_press = 1'b0; p_err = 1'b0;
    p_scan = '0; p_force = '0; p_pm = '0;
  endtask

  task automatic step(
    input bit v, input logic [3:0] k, input logic [15:0] h,
    input logic [11:0] f, input logic [3:0] s);
    logic [11:0] e_pm;
    logic [2:0]  e_sn;
    bit          e_busy, e_done;
    @(posedge clk); #1; cyc++;
    e_pm   = p_force | (p_press ? key_bit(p_key) : 12'h0);
    e_sn   = sense_of(p_scan, p_pm);
    e_busy = m_act && cyc > m_a && cyc <= m_aend;
    e_done = m_act && cyc == m_aend;
    check("pressed_map", 16'(pressed_map), 16'(e_pm));
    check("sense_out", 16'(sense_out), 16'(e_sn));
    check("busy", 16'(busy), 16'(e_busy));
    check("cmd_ready", 16'(cmd_ready), 16'(!e_busy));
    check("done", 16'(done), 16'(e_done));
    check("err", 16'(err), 16'(p_err));
    if (done) done_cnt++;
    if (pressed_map == 12'h010) plen++;
    cmd_valid = v; cmd_key = k; cmd_hold = h;
    force_map = f; scan_in = s;
    p_press = m_act && cyc > m_a && cyc <= m_pend;
    p_key   = m_key;
    p_force = f; p_scan = s; p_pm = e_pm; p_err = 1'b0;
    if (v && !e_busy) begin
      if (k > 4'd11) begin
        p_err = 1'b1;
      end else begin
        m_act  = 1'b1;
        m_a    = cyc;
        m_key  = k;
        m_pend = cyc + ((h == 16'd0) ? 1 : int'(h)) * TD;
        m_aend = m_pend + ((G == 0) ? 1 : G * TD);
      end
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    cmd_valid = 1'b0; force_map = '0; scan_in = '0;
    #1;
    check("rst_sense", 16'(sense_out), 16'h0);
    check("rst_map", 16'(pressed_map), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    check("rst_err", 16'(err), 16'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    model_clear();
  endtask

  task automatic idle(input int n, input logic [11:0] f,
                      input logic [3:0] s);
    repeat (n) step(1'b0, 4'd0, 16'd0, f, s);
  endtask

  initial begin
    int a0;
    logic [3:0] sc;
    #12 rst = 1'b1;
    model_clear();

    // reset in the middle of a long press of key "6"
    step(1'b1, 4'd5, 16'd10, 12'h0, 4'b0010);
    idle(9, 12'h0, 4'b0010);
    check("mid_busy", 16'(busy), 16'h1);
    do_reset();
    idle(2, 12'h0, 4'b0000);

    // key "5" held 3 ticks, scanned on line 1
    plen = 0; done_cnt = 0;
    step(1'b1, 4'd4, 16'd3, 12'h0, 4'b0010);
    idle(26, 12'h0, 4'b0010);
    check("press_len", 16'(plen), 16'd12);
    check("press_done", 16'(done_cnt), 16'd1);

    // force "1" and "#", sweep scan lines
    for (int r = 0; r < 8; r++) begin
      sc = 4'b0001 << (r % 4);
      step(1'b0, 4'd0, 16'd0, 12'h801, sc);
    end

    // illegal key
    step(1'b1, 4'd13, 16'd5, 12'h801, 4'b0001);
    idle(4, 12'h801, 4'b0001);

    // back-to-back commands, second one held until ready
    done_cnt = 0;
    step(1'b1, 4'd0, 16'd1, 12'h0, 4'b0001);
    a0 = m_a;
    for (int i = 0; i < 40 && m_a == a0; i++)
      step(1'b1, 4'd2, 16'd0, 12'h0, 4'b0001);
    idle(20, 12'h0, 4'b0001);
    check("bp_dones", 16'(done_cnt), 16'd2);

    // two lines active at once, force key "4"
    idle(4, 12'h008, 4'b0011);
    check("multi_sense", 16'(sense_out), 16'b001);

    for (int i = 0; i < 3000; i++) begin
      logic [11:0] f;
      logic [3:0]  s;
      int          sel;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        continue;
      end
      f = ($urandom_range(0, 9) < 7) ? 12'h0 : 12'($urandom);
      sel = $urandom_range(0, 3);
      s = (sel == 0) ? 4'b0 :
          (sel == 3) ? 4'($urandom) :
          4'b0001 << $urandom_range(0, 3);
      step($urandom_range(0, 3) == 0,
           4'($urandom_range(0, 13)),
           16'($urandom_range(0, 3)), f, s);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
